// File: rtl/aes_core_stream.sv
// AES-128/192/256 encryption core: one-time key expansion into a round-key file, then an iterative one-round-per-cycle block cipher.
// Latency: NR edges from the accept edge to out_valid. Key expansion takes 4*(NR+1)-NK edges after key_load.
// Backpressure: val/out_valid are held while out_ready is low, and in_ready stays low until the result drains.
//
// Ports: sclk/srst (async active-high) | key_load, key[255:0] (byte 0 in bits 255:248), key_ready
//        in_valid/in_ready, text[127:0] (byte 0 in bits 127:120) | out_valid/out_ready, val[127:0]
// Optional macro AES_BLK_CNT_EN adds blk_cnt[31:0]: a saturating count of output handshakes, cleared by key_load.
module aes_core_stream #(
  parameter int KEY_BITS = 128
) (
  input  logic         sclk,
  input  logic         srst,
  input  logic         key_load,
  input  logic [255:0] key,
  output logic         key_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] text,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] val
`ifdef AES_BLK_CNT_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);
  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LAST6 = 6'(NW - 1);
  localparam logic [2:0] NK_M1 = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_core_stream: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [2:0] {IDLE, KEXP, READY, RUN, HOLD} state_t;

  // ---------------------------------------------------------------- GF(2^8) helpers
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254, with 0 mapping to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = a;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[8*b +: 8] = sbox(s[8*b +: 8]);
    return r;
  endfunction

  // Byte n = 4*column + row. Row r of the output takes the column (c + r) mod 4 of the input.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = s[127 - 8*(4*((c + row) % 4) + row) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      r[127 - 32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  state_t       st_q;
  logic [3:0]   round_q;
  logic [5:0]   wcnt_q;   // index of the next round-key word to produce
  logic [2:0]   kmod_q;   // wcnt_q mod NK, tracked incrementally
  logic [7:0]   rcon_q;
  logic [127:0] blk_q;
  logic         key_ready_q;
  logic         out_valid_q;
  logic [127:0] val_q;
`ifdef AES_BLK_CNT_EN
  logic [31:0]  blk_cnt_q;
`endif

  logic [31:0]  w_rd [NW];
  logic [31:0]  kw_prev, kw_tmp, kw_d;
  logic [127:0] rk0, rk_cur, sr, mc, blk_d;
  logic [5:0]   rk_idx;
  logic         accept, drain;
  logic         unused_key;

  // Bytes above KEY_BITS/8 are don't-care.
  assign unused_key = ^key;

  // ---------------------------------------------------------------- round-key file (no reset: contents are don't-care until re-expanded)
  for (genvar g = 0; g < NW; g++) begin : g_w
    localparam logic [5:0] IDX = 6'(g);
    logic [31:0] w_q;
    if (g < NK) begin : g_key
      always_ff @(posedge sclk) begin
        if (key_load) w_q <= key[255 - 32*g -: 32];
      end
    end else begin : g_exp
      always_ff @(posedge sclk) begin
        if (!key_load && st_q == KEXP && wcnt_q == IDX) w_q <= kw_d;
      end
    end
    assign w_rd[g] = w_q;
  end

  always_comb begin
    kw_prev = w_rd[wcnt_q - 6'd1];
    if (kmod_q == 3'd0)
      kw_tmp = sub_word({kw_prev[23:0], kw_prev[31:24]}) ^ {rcon_q, 24'h0};
    else if (NK == 8 && kmod_q == 3'd4)
      kw_tmp = sub_word(kw_prev);
    else
      kw_tmp = kw_prev;
    kw_d = w_rd[wcnt_q - NK6] ^ kw_tmp;
  end

  // ---------------------------------------------------------------- round datapath
  assign rk_idx = {round_q, 2'b00};
  assign rk0    = {w_rd[0], w_rd[1], w_rd[2], w_rd[3]};
  assign rk_cur = {w_rd[rk_idx], w_rd[rk_idx + 6'd1], w_rd[rk_idx + 6'd2], w_rd[rk_idx + 6'd3]};

  always_comb begin
    sr    = shift_rows(sub_bytes(blk_q));
    mc    = (round_q == NR4) ? sr : mix_columns(sr);
    blk_d = mc ^ rk_cur;
  end

  // ---------------------------------------------------------------- handshakes
  assign in_ready  = key_ready_q && st_q != RUN && (st_q != HOLD || out_ready);
  assign accept    = in_valid && in_ready && !key_load;
  assign drain     = out_valid_q && out_ready;
  assign key_ready = key_ready_q;
  assign out_valid = out_valid_q;
  assign val       = val_q;
`ifdef AES_BLK_CNT_EN
  assign blk_cnt   = blk_cnt_q;
`endif

  // ---------------------------------------------------------------- control FSM
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      st_q        <= IDLE;
      round_q     <= 4'd0;
      wcnt_q      <= 6'd0;
      kmod_q      <= 3'd0;
      rcon_q      <= 8'h01;
      blk_q       <= '0;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      val_q       <= '0;
`ifdef AES_BLK_CNT_EN
      blk_cnt_q   <= '0;
`endif
    end else if (key_load) begin
      // A new key aborts whatever is in flight, including an undrained result.
      st_q        <= KEXP;
      round_q     <= 4'd0;
      wcnt_q      <= NK6;
      kmod_q      <= 3'd0;
      rcon_q      <= 8'h01;
      key_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef AES_BLK_CNT_EN
      blk_cnt_q   <= '0;
`endif
    end else begin
`ifdef AES_BLK_CNT_EN
      if (drain && blk_cnt_q != 32'hFFFF_FFFF) blk_cnt_q <= blk_cnt_q + 32'd1;
`endif
      case (st_q)
        KEXP: begin
          kmod_q <= (kmod_q == NK_M1) ? 3'd0 : kmod_q + 3'd1;
          if (kmod_q == 3'd0) rcon_q <= xtime(rcon_q);
          if (wcnt_q == LAST6) begin
            key_ready_q <= 1'b1;
            st_q        <= READY;
            wcnt_q      <= 6'd0;
          end else begin
            wcnt_q <= wcnt_q + 6'd1;
          end
        end
        READY: begin
          if (accept) begin
            blk_q   <= text ^ rk0;
            round_q <= 4'd1;
            st_q    <= RUN;
          end
        end
        RUN: begin
          blk_q <= blk_d;
          if (round_q == NR4) begin
            val_q       <= blk_d;
            out_valid_q <= 1'b1;
            round_q     <= 4'd0;
            st_q        <= HOLD;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        HOLD: begin
          // in_ready in HOLD implies out_ready, so an accept here always drains too.
          if (accept) begin
            blk_q       <= text ^ rk0;
            round_q     <= 4'd1;
            out_valid_q <= 1'b0;
            st_q        <= RUN;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            st_q        <= READY;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_core_stream.sv
// Bench for aes_core_stream: three instances (AES-128/192/256) on one clock.
// Known-answer vectors plus randomized streaming against a byte-level AES reference model.
// Covers backpressure, abort by key_load and asynchronous reset.
module tb_aes_core_stream;

  logic clk = 1'b0;
  logic srst;
  logic [2:0] kl, kr, iv, ir, ov, ordy;
  logic [2:0][255:0] k;
  logic [2:0][127:0] txt, v;
`ifdef AES_BLK_CNT_EN
  logic [2:0][31:0] bc;
`endif
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_core_stream #(.KEY_BITS(128 + 64*g)) u_dut (
      .sclk(clk), .srst(srst), .key_load(kl[g]), .key(k[g]), .key_ready(kr[g]),
      .in_valid(iv[g]), .in_ready(ir[g]), .text(txt[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .val(v[g])
`ifdef AES_BLK_CNT_EN
      , .blk_cnt(bc[g])
`endif
    );
  end

  logic [127:0] sbox_rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [127:0] row;
    row = sbox_rows[x[7:4]];
    return row[127 - 8*x[3:0] -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte-matrix AES straight from FIPS-197: s[row][col], key bytes from the top of key_in.
  function automatic logic [127:0] aes_ref(input logic [255:0] key_in, input int kbits, input logic [127:0] pt);
    int nk, nr;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0] s [4][4];
    logic [7:0] t [4][4];
    logic [7:0] rcon [10];
    logic [127:0] ct;
    rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    nk = kbits / 32;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key_in[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0)
        tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rcon[i/nk - 1], 24'h0};
      else if (nk == 8 && i % nk == 4)
        tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])};
      w[i] = w[i-nk] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r][c] = pt[127 - 8*(4*c + r) -: 8] ^ w[c][31 - 8*r -: 8];
    for (int rnd = 1; rnd <= nr; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb(s[r][(c + r) % 4]);
      for (int c = 0; c < 4; c++) begin
        if (rnd != nr) begin
          s[0][c] = xt(t[0][c]) ^ xt(t[1][c]) ^ t[1][c] ^ t[2][c] ^ t[3][c];
          s[1][c] = t[0][c] ^ xt(t[1][c]) ^ xt(t[2][c]) ^ t[2][c] ^ t[3][c];
          s[2][c] = t[0][c] ^ t[1][c] ^ xt(t[2][c]) ^ xt(t[3][c]) ^ t[3][c];
          s[3][c] = xt(t[0][c]) ^ t[0][c] ^ t[1][c] ^ t[2][c] ^ xt(t[3][c]);
        end else begin
          for (int r = 0; r < 4; r++) s[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ w[4*rnd + c][31 - 8*r -: 8];
      end
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        ct[127 - 8*(4*c + r) -: 8] = s[r][c];
    return ct;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input int d, input logic [255:0] key_in, input int exp_cyc);
    int cnt = 0;
    int ov_seen = 0;
    k[d] = key_in;
    kl[d] = 1'b1;
    tick();
    kl[d] = 1'b0;
    check("kl_kr_drop", kr[d], 1'b0);
    check("kl_ov_drop", ov[d], 1'b0);
`ifdef AES_BLK_CNT_EN
    check("kl_blkcnt_clr", bc[d], 0);
`endif
    while (!kr[d] && cnt < 200) begin
      tick();
      cnt++;
      if (ov[d]) ov_seen++;
    end
    check("key_latency", cnt, exp_cyc);
    check("kexp_no_ov", ov_seen, 0);
  endtask

  task automatic wait_ov(input int d, input int exp_lat);
    int cnt = 0;
    while (!ov[d] && cnt < 100) begin
      tick();
      cnt++;
    end
    check("ct_latency", cnt, exp_lat);
  endtask

  task automatic send_block(input int d, input logic [127:0] pt, input logic [127:0] exp_ct);
    ordy[d] = 1'b1;
    iv[d] = 1'b1;
    txt[d] = pt;
    #1;
    check("acc_rdy", ir[d], 1'b1);
    tick();
    iv[d] = 1'b0;
    wait_ov(d, 10 + 2*d);
    check("ct_kat", v[d], exp_ct);
    check("ct_model", v[d], aes_ref(k[d], 128 + 64*d, pt));
    tick();
    check("ct_drained", ov[d], 1'b0);
  endtask

  task automatic stream(input int d, input int nblk, input int stall_pct);
    logic [127:0] pend [$];
    logic [127:0] expq [$];
    logic [127:0] val_prev;
    int busy = 0;
    int cyc = 0;
    int nr = 10 + 2*d;
    bit hold = 0;
    bit stall_prev;
    bit acc, drn;
    for (int i = 0; i < nblk; i++) pend.push_back({$urandom, $urandom, $urandom, $urandom});
    while ((pend.size() > 0 || expq.size() > 0) && cyc < 3000) begin
      iv[d] = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
      txt[d] = (pend.size() > 0) ? pend[0] : 128'h0;
      ordy[d] = ($urandom_range(0, 99) >= stall_pct);
      #1;
      check("str_out_valid", ov[d], hold);
      check("str_in_ready", ir[d], busy == 0 && (!hold || ordy[d]));
      acc = iv[d] && ir[d];
      drn = ov[d] && ordy[d];
      if (drn && expq.size() > 0) begin
        check("str_val", v[d], expq[0]);
        void'(expq.pop_front());
      end
      if (acc) begin
        expq.push_back(aes_ref(k[d], 128 + 64*d, pend[0]));
        void'(pend.pop_front());
      end
      stall_prev = ov[d] && !ordy[d];
      val_prev = v[d];
      tick();
      if (stall_prev) check("str_val_stable", v[d], val_prev);
      if (drn) hold = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) hold = 1;
      end
      if (acc) busy = nr;
      cyc++;
    end
    iv[d] = 1'b0;
    ordy[d] = 1'b0;
    check("str_done", pend.size() + expq.size(), 0);
`ifdef AES_BLK_CNT_EN
    check("str_blkcnt", bc[d], nblk);
`endif
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B1   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] KEYA = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

  initial begin
    logic [255:0] kat_key [3];
    logic [127:0] kat_ct [3];
    int bad;
    kat_key = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
    kat_ct  = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                128'h8ea2b7ca516745bfeafc49904b496089};
    srst = 1'b0; kl = '0; k = '0; iv = '0; txt = '0; ordy = '0;
    #2 srst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      check("rst_key_ready", kr[d], 1'b0);
      check("rst_in_ready", ir[d], 1'b0);
      check("rst_out_valid", ov[d], 1'b0);
      check("rst_val", v[d], 128'h0);
    end
    #19 srst = 1'b0;
    tick();

    // in_valid before any key is ignored
    bad = 0;
    iv[0] = 1'b1; txt[0] = PT; ordy[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (ir[0] || ov[0]) bad++;
      tick();
    end
    iv[0] = 1'b0;
    check("nokey_ignored", bad, 0);

    // Known answers, then random streaming, for each key size
    for (int d = 0; d < 3; d++) begin
      load_key(d, kat_key[d], 40 + 6*d);
      send_block(d, PT, kat_ct[d]);
      load_key(d, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 40 + 6*d);
      stream(d, 8, 35);
    end

    // Backpressure: 5-cycle stall, second block accepted in the drain cycle
    load_key(0, KEYA, 40);
    ordy[0] = 1'b0; iv[0] = 1'b1; txt[0] = B1;
    #1;
    check("bp_acc_rdy", ir[0], 1'b1);
    tick();
    iv[0] = 1'b0;
    wait_ov(0, 10);
    check("bp_val", v[0], 128'h3925841d02dc09fbdc118597196a0b32);
    iv[0] = 1'b1; txt[0] = PT;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_stall_in_ready", ir[0], 1'b0);
      check("bp_stall_out_valid", ov[0], 1'b1);
      check("bp_stall_val", v[0], 128'h3925841d02dc09fbdc118597196a0b32);
      tick();
    end
    ordy[0] = 1'b1;
    #1;
    check("bp_drain_in_ready", ir[0], 1'b1);
    tick();
    iv[0] = 1'b0;
    check("bp_ov_after_drain", ov[0], 1'b0);
    wait_ov(0, 10);
    check("bp_val2", v[0], aes_ref(KEYA, 128, PT));
    tick();
    check("bp_ov_done", ov[0], 1'b0);
`ifdef AES_BLK_CNT_EN
    check("bp_blkcnt", bc[0], 2);
`endif

    // Abort: key_load while the block is in round 5
    load_key(0, kat_key[0], 40);
    ordy[0] = 1'b1; iv[0] = 1'b1; txt[0] = PT;
    tick();
    iv[0] = 1'b0;
    repeat (4) tick();
    check("abort_no_ov_yet", ov[0], 1'b0);
    load_key(0, KEYA, 40);
    send_block(0, B1, 128'h3925841d02dc09fbdc118597196a0b32);

    // Asynchronous reset during HOLD
    ordy[0] = 1'b0; iv[0] = 1'b1; txt[0] = PT;
    tick();
    iv[0] = 1'b0;
    wait_ov(0, 10);
    iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    check("rst_pre_in_ready", ir[0], 1'b1);
    #2 srst = 1'b1;
    #1;
    check("arst_out_valid", ov[0], 1'b0);
    check("arst_key_ready", kr[0], 1'b0);
    check("arst_in_ready", ir[0], 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 srst = 1'b0;
    tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (ir[0] || ov[0]) bad++;
      tick();
    end
    iv[0] = 1'b0;
    check("post_rst_ignored", bad, 0);
    load_key(0, kat_key[0], 40);
    send_block(0, PT, kat_ct[0]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
